// File: rtl/csi2_pkt_if.sv
// Handshake/bus bundle between the word aligner side and csi2_pkt_ctrl.
// master = aligner/config side, slave = packet controller.
interface csi2_pkt_if #(
  parameter int DATA_LANES = 4
);
  logic                    hs_enable;
  logic [DATA_LANES*8-1:0] word;
  logic                    valid;
  logic                    align_enable;
  logic                    eop;
  logic                    hdr_valid;
  logic [7:0]              pkt_di;
  logic [15:0]             pkt_wc;
  logic [7:0]              pkt_ecc;
  logic                    short_pkt;
  logic [DATA_LANES*8-1:0] payload;
  logic [DATA_LANES-1:0]   payload_strb;
  logic                    payload_valid;
  logic                    payload_last;
  logic                    err_trunc;
  logic                    err_len;

  modport master (
    output hs_enable, word, valid,
    input  align_enable, eop, hdr_valid,
    input  pkt_di, pkt_wc, pkt_ecc, short_pkt,
    input  payload, payload_strb, payload_valid,
    input  payload_last, err_trunc, err_len
  );

  modport slave (
    input  hs_enable, word, valid,
    output align_enable, eop, hdr_valid,
    output pkt_di, pkt_wc, pkt_ecc, short_pkt,
    output payload, payload_strb, payload_valid,
    output payload_last, err_trunc, err_len
  );
endinterface

// File: rtl/csi2_pkt_ctrl.sv
// CSI-2 packet sequencer: header parse, payload/CRC byte counting,
// payload forwarding with byte strobes, truncation and length errors.
module csi2_pkt_ctrl #(
  parameter int DATA_LANES = 4,
  parameter int MAX_WC     = 4096
) (
  input logic       byte_clk,
  input logic       rst,
  csi2_pkt_if.slave bus
);
  localparam logic [2:0]  LB   = 3'(DATA_LANES);
  localparam logic [16:0] LW   = 17'(DATA_LANES);
  localparam logic [16:0] MAXW = 17'(MAX_WC);

  typedef enum logic [1:0] {
    IDLE, HEADER, PAYLOAD, WAIT_LOW
  } state_t;

  state_t st_q, st_d, hdr_st;

  logic [31:0]           hdr_q, hdr_d;
  logic [2:0]            hcnt_q, hbase, hnext;
  logic [16:0]           rem_q;
  logic signed [17:0]    avail;
  logic [DATA_LANES-1:0] strb_c;
  logic [7:0]            di_c;
  logic [15:0]           wc_c;
  logic go, take_hdr, hdr_last;
  logic is_short, too_long;
  logic last_w, pay_word, abort;

  assign go = bus.valid && bus.hs_enable;

  always_comb begin
    hbase = (st_q == HEADER) ? hcnt_q : 3'd0;
    hnext = hbase + LB;
    hdr_d = hdr_q;
    // Lane 0 is the earliest byte; header bytes fill from the bottom.
    for (int i = 0; i < DATA_LANES; i++) begin
      if (int'(hbase) + i < 4)
        hdr_d[(int'(hbase) + i)*8 +: 8] = bus.word[i*8 +: 8];
    end
    di_c     = hdr_d[7:0];
    wc_c     = hdr_d[23:8];
    is_short = di_c[5:0] <= 6'h0F;
    too_long = {1'b0, wc_c} > MAXW;
    take_hdr = go && (st_q == IDLE || st_q == HEADER);
    hdr_last = take_hdr && (hnext == 3'd4);
    hdr_st   = (is_short || too_long) ? WAIT_LOW : PAYLOAD;
    last_w   = rem_q <= LW;
    // A last word completes even if enable drops with it.
    pay_word = (st_q == PAYLOAD) && bus.valid &&
               (bus.hs_enable || last_w);
    abort    = ((st_q == HEADER) && !go) ||
               ((st_q == PAYLOAD) && !pay_word);
    avail    = $signed({1'b0, rem_q}) - 18'sd2;
    strb_c   = '0;
    for (int i = 0; i < DATA_LANES; i++)
      strb_c[i] = avail > $signed(18'(i));
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: begin
        if (take_hdr)
          st_d = hdr_last ? hdr_st : HEADER;
      end
      HEADER: begin
        if (abort)         st_d = IDLE;
        else if (hdr_last) st_d = hdr_st;
      end
      PAYLOAD: begin
        if (abort)                   st_d = IDLE;
        else if (pay_word && last_w) st_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!bus.valid) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge byte_clk) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  always_ff @(posedge byte_clk) begin
    if (rst) begin
      hdr_q             <= '0;
      hcnt_q            <= '0;
      rem_q             <= '0;
      bus.align_enable  <= 1'b0;
      bus.eop           <= 1'b0;
      bus.hdr_valid     <= 1'b0;
      bus.pkt_di        <= '0;
      bus.pkt_wc        <= '0;
      bus.pkt_ecc       <= '0;
      bus.short_pkt     <= 1'b0;
      bus.payload       <= '0;
      bus.payload_strb  <= '0;
      bus.payload_valid <= 1'b0;
      bus.payload_last  <= 1'b0;
      bus.err_trunc     <= 1'b0;
      bus.err_len       <= 1'b0;
    end else begin
      bus.align_enable  <= bus.hs_enable;
      bus.hdr_valid     <= hdr_last;
      bus.eop           <= (hdr_last && (is_short || too_long)) ||
                           (pay_word && last_w);
      bus.err_len       <= hdr_last && !is_short && too_long;
      bus.err_trunc     <= abort;
      bus.payload_valid <= pay_word;
      bus.payload_last  <= pay_word && last_w;
      if (take_hdr) hdr_q <= hdr_d;
      hcnt_q <= (take_hdr && !hdr_last) ? hnext : 3'd0;
      if (hdr_last) begin
        bus.pkt_di    <= di_c;
        bus.pkt_wc    <= wc_c;
        bus.pkt_ecc   <= hdr_d[31:24];
        bus.short_pkt <= is_short;
        // Payload plus the 2 CRC bytes still to be seen.
        rem_q         <= {1'b0, wc_c} + 17'd2;
      end else if (pay_word && !last_w) begin
        rem_q <= rem_q - LW;
      end
      if (pay_word) begin
        bus.payload      <= bus.word;
        bus.payload_strb <= strb_c;
      end
    end
  end
endmodule

// File: tb/tb_csi2_pkt_ctrl.sv
// Bench for csi2_pkt_ctrl: 4-lane and 2-lane instances, directed
// packets then random packets against a byte-stream reference model.
module tb_csi2_pkt_ctrl;
  localparam int MAX_WC = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csi2_pkt_if #(.DATA_LANES(4)) if4 ();
  csi2_pkt_if #(.DATA_LANES(2)) if2 ();

  csi2_pkt_ctrl #(.DATA_LANES(4), .MAX_WC(MAX_WC)) u4 (
    .byte_clk(clk), .rst(rst), .bus(if4)
  );
  csi2_pkt_ctrl #(.DATA_LANES(2), .MAX_WC(MAX_WC)) u2 (
    .byte_clk(clk), .rst(rst), .bus(if2)
  );

  typedef struct {
    int cyc; logic [7:0] di; logic [15:0] wc; logic [7:0] ecc;
    logic sp; logic eop; logic len;
  } hrec_t;
  typedef struct {
    int cyc; logic [31:0] data; logic [3:0] strb;
    logic last; logic eop;
  } prec_t;

  hrec_t hq[$];
  prec_t pq[$];
  logic [7:0] pb[$];
  int cyc = 0;
  int sent = 0;
  int n_eop = 0, n_trunc = 0, n_len = 0;
  int n_err = 0, n_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if4.hdr_valid)
      hq.push_back('{cyc, if4.pkt_di, if4.pkt_wc, if4.pkt_ecc,
                     if4.short_pkt, if4.eop, if4.err_len});
    if (if2.hdr_valid)
      hq.push_back('{cyc, if2.pkt_di, if2.pkt_wc, if2.pkt_ecc,
                     if2.short_pkt, if2.eop, if2.err_len});
    if (if4.payload_valid)
      pq.push_back('{cyc, if4.payload, if4.payload_strb,
                     if4.payload_last, if4.eop});
    if (if2.payload_valid)
      pq.push_back('{cyc, {16'h0, if2.payload},
                     {2'b00, if2.payload_strb},
                     if2.payload_last, if2.eop});
    if (if4.eop) n_eop++;
    if (if2.eop) n_eop++;
    if (if4.err_trunc) n_trunc++;
    if (if2.err_trunc) n_trunc++;
    if (if4.err_len) n_len++;
    if (if2.err_len) n_len++;
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] outs4();
    return {if4.align_enable, if4.eop, if4.hdr_valid,
            if4.pkt_di, if4.pkt_wc, if4.pkt_ecc, if4.short_pkt,
            if4.payload, if4.payload_strb, if4.payload_valid,
            if4.payload_last, if4.err_trunc, if4.err_len};
  endfunction

  function automatic logic [127:0] outs2();
    return {if2.align_enable, if2.eop, if2.hdr_valid,
            if2.pkt_di, if2.pkt_wc, if2.pkt_ecc, if2.short_pkt,
            if2.payload, if2.payload_strb, if2.payload_valid,
            if2.payload_last, if2.err_trunc, if2.err_len};
  endfunction

  function automatic logic [31:0] mkword(input int lanes,
                                         input int base);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < lanes; i++) w[i*8 +: 8] = pb[base + i];
    return w;
  endfunction

  // Lane i of word k is payload iff its byte offset is below WC.
  function automatic logic [3:0] exp_strb(input int lanes,
                                          input int k,
                                          input int wc);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < lanes; i++) s[i] = (k*lanes + i) < wc;
    return s;
  endfunction

  task automatic drive(input int lanes, input logic v,
                       input logic en, input logic [31:0] w);
    @(negedge clk);
    if (lanes == 4) begin
      if4.valid = v; if4.hs_enable = en; if4.word = w;
    end else begin
      if2.valid = v; if2.hs_enable = en; if2.word = w[15:0];
    end
    sent = cyc;
  endtask

  task automatic clear_obs();
    hq.delete(); pq.delete();
    n_eop = 0; n_trunc = 0; n_len = 0;
  endtask

  task automatic send_pkt(input int lanes, input logic [7:0] di,
                          input logic [15:0] wc,
                          input int stop_at, input int hs_at);
    logic sp, tl, ok, trunc, hsd;
    int nw, nd, hcyc;
    int pc[$];
    sp = di[5:0] <= 6'h0F;
    tl = !sp && (int'(wc) > MAX_WC);
    ok = !sp && !tl;
    nw = ok ? (int'(wc) + 2 + lanes - 1) / lanes : 0;
    pb.delete();
    pb.push_back(di); pb.push_back(wc[7:0]);
    pb.push_back(wc[15:8]); pb.push_back(8'($urandom));
    for (int i = 0; i < nw*lanes; i++) pb.push_back(8'($urandom));
    clear_obs();
    hcyc = 0; nd = 0; trunc = 0; hsd = 0;
    for (int h = 0; h < 4/lanes; h++) begin
      drive(lanes, 1'b1, 1'b1, mkword(lanes, h*lanes));
      hcyc = sent;
    end
    for (int k = 0; k < nw; k++) begin
      if (k == stop_at) begin trunc = 1; break; end
      if (k == hs_at) begin
        drive(lanes, 1'b1, 1'b0, mkword(lanes, 4 + k*lanes));
        hsd = 1;
        if (k != nw - 1) begin trunc = 1; break; end
      end else begin
        drive(lanes, 1'b1, 1'b1, mkword(lanes, 4 + k*lanes));
      end
      pc.push_back(sent);
      nd++;
    end
    drive(lanes, 1'b0, !hsd, '0);
    if (hsd)
      chk("align_en_low",
          lanes == 4 ? if4.align_enable : if2.align_enable, 0);
    repeat (4) drive(lanes, 1'b0, 1'b1, '0);
    chk("hdr_cnt", hq.size(), 1);
    if (hq.size() == 1) begin
      chk("hdr_lat", hq[0].cyc, hcyc + 1);
      chk("hdr_di", hq[0].di, di);
      chk("hdr_wc", hq[0].wc, wc);
      chk("hdr_ecc", hq[0].ecc, pb[3]);
      chk("hdr_short", hq[0].sp, sp);
      chk("hdr_eop", hq[0].eop, sp || tl);
      chk("hdr_len", hq[0].len, tl);
    end
    chk("pay_cnt", pq.size(), nd);
    for (int k = 0; k < nd && k < pq.size(); k++) begin
      chk("pay_lat", pq[k].cyc, pc[k] + 1);
      chk("pay_data", pq[k].data, mkword(lanes, 4 + k*lanes));
      chk("pay_strb", pq[k].strb, exp_strb(lanes, k, int'(wc)));
      chk("pay_last", pq[k].last, k == nw - 1);
      chk("pay_eop", pq[k].eop, k == nw - 1);
    end
    chk("eop_cnt", n_eop, (sp || tl || !trunc) ? 1 : 0);
    chk("trunc_cnt", n_trunc, trunc ? 1 : 0);
    chk("len_cnt", n_len, tl ? 1 : 0);
  endtask

  int lanes, nwr, sa, ha;
  logic [7:0] rdi;
  logic [15:0] rwc;

  initial begin
    if4.valid = 0; if4.hs_enable = 0; if4.word = '0;
    if2.valid = 0; if2.hs_enable = 0; if2.word = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs4", outs4(), 0);
    chk("reset_outs2", outs2(), 0);
    rst = 1'b0;
    if4.hs_enable = 1; if2.hs_enable = 1;
    repeat (2) @(negedge clk);
    chk("align_en_high", if4.align_enable, 1);

    send_pkt(4, 8'h00, 16'h0001, -1, -1);
    send_pkt(4, 8'h2A, 16'd6, -1, -1);
    send_pkt(4, 8'h2A, 16'd3, -1, -1);
    send_pkt(4, 8'h2A, 16'd0, -1, -1);
    send_pkt(2, 8'h2B, 16'd5, -1, -1);
    send_pkt(4, 8'h2A, 16'd16, 1, -1);
    send_pkt(4, 8'h2A, 16'd6, -1, -1);
    send_pkt(4, 8'h2A, 16'hFFFF, -1, -1);
    send_pkt(4, 8'h2A, 16'd16, -1, 2);
    send_pkt(4, 8'h2A, 16'd6, -1, 1);
    send_pkt(2, 8'h12, 16'd4096, -1, -1);
    send_pkt(2, 8'h12, 16'd4097, -1, -1);

    // Words arriving while receive is disabled are ignored.
    clear_obs();
    drive(4, 1'b1, 1'b0, 32'h5C00062A);
    drive(4, 1'b1, 1'b0, 32'h11223344);
    repeat (4) drive(4, 1'b0, 1'b1, '0);
    chk("dis_hdr", hq.size(), 0);
    chk("dis_pay", pq.size(), 0);
    chk("dis_evt", n_eop + n_trunc + n_len, 0);

    // Valid drops in the middle of a 2-lane header.
    clear_obs();
    drive(2, 1'b1, 1'b1, 32'h0000062A);
    repeat (4) drive(2, 1'b0, 1'b1, '0);
    chk("hdr_abort_hdr", hq.size(), 0);
    chk("hdr_abort_trunc", n_trunc, 1);
    chk("hdr_abort_eop", n_eop, 0);

    // Reset in the middle of a payload.
    pb.delete();
    pb.push_back(8'h2A); pb.push_back(8'd16);
    pb.push_back(8'd0); pb.push_back(8'h5C);
    for (int i = 0; i < 20; i++) pb.push_back(8'($urandom));
    drive(4, 1'b1, 1'b1, mkword(4, 0));
    drive(4, 1'b1, 1'b1, mkword(4, 4));
    @(negedge clk);
    rst = 1'b1; if4.word = mkword(4, 8);
    @(negedge clk);
    chk("rst_mid_outs", outs4(), 0);
    rst = 1'b0; if4.valid = 0;
    clear_obs();
    repeat (4) drive(4, 1'b0, 1'b1, '0);
    chk("rst_mid_trunc", n_trunc, 0);
    chk("rst_mid_hdr", hq.size(), 0);
    send_pkt(4, 8'h2A, 16'd6, -1, -1);

    for (int n = 0; n < 40; n++) begin
      lanes = (n % 4 == 3) ? 2 : 4;
      rdi = 8'($urandom);
      if ($urandom_range(0, 7) == 0)
        rwc = 16'($urandom_range(4097, 65535));
      else
        rwc = 16'($urandom_range(0, 40));
      nwr = (int'(rwc) + 2 + lanes - 1) / lanes;
      sa = ($urandom_range(0, 5) == 0) ?
           int'($urandom_range(0, nwr - 1)) : -1;
      ha = ($urandom_range(0, 5) == 0) ?
           int'($urandom_range(0, nwr - 1)) : -1;
      send_pkt(lanes, rdi, rwc, sa, ha);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
